cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache.
- Converts each 256-bit cacheline read or write request into a 4-beat, 64-bit burst on the physical memory bus.
- Upstream side is the L2 `pmem_*` single-line handshake; downstream side is the burst DRAM model or controller.
- Only one transaction is outstanding at a time.

Parameters:
- BEAT_W, 64, width of one memory burst beat in bits.
- BEATS, 4, beats per cacheline. LINE_W = BEAT_W*BEATS = 256.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- line_address_i  input  ADDR_W  line address from L2.
- line_wdata_i  input  LINE_W  line to write, from L2.
- line_rdata_o  output  LINE_W  assembled line returned to L2.
- line_read_i  input  1  L2 read request, held until line_resp_o.
- line_write_i  input  1  L2 write request, held until line_resp_o.
- line_resp_o  output  1  one-cycle completion pulse to L2.
- burst_address_o  output  ADDR_W  line-aligned burst address.
- burst_rdata_i  input  BEAT_W  read beat from memory.
- burst_wdata_o  output  BEAT_W  write beat to memory.
- burst_read_o  output  1  burst read request.
- burst_write_o  output  1  burst write request.
- burst_resp_i  input  1  memory beat strobe; one beat transferred per cycle it is high.

Behaviour:
- Reset (rst low, async):
  - State IDLE, beat counter = 0.
  - line_rdata_o = 0, line_resp_o = 0, burst_read_o = 0, burst_write_o = 0.
  - burst_address_o = 0, burst_wdata_o = 0.
  - Any burst in flight is abandoned; no resp is issued for it.
- State IDLE:
  - line_write_i high: capture line_wdata_i into the line buffer, capture {line_address_i[ADDR_W-1:5],5'b0} into the address register, go to WRITE.
  - Else line_read_i high: capture the aligned address, go to READ.
  - Write has priority if both requests are high; read is then ignored until that write completes.
  - Address low 5 bits are always forced to zero.
- State READ:
  - burst_read_o = 1; burst_address_o = latched address.
  - Each cycle burst_resp_i = 1: write burst_rdata_i into line buffer slice [cnt*64 +: 64], then cnt++.
  - Gaps (burst_resp_i = 0) between beats are legal; hold state and counter.
  - When the beat with cnt == BEATS-1 is accepted: cnt wraps to 0, go to DONE.
  - burst_read_o drops the cycle after the last beat.
- State WRITE:
  - burst_write_o = 1; burst_wdata_o = line buffer slice [cnt*64 +: 64], registered-stable while waiting.
  - Each cycle burst_resp_i = 1, that beat is consumed and cnt++.
  - After beat BEATS-1 is consumed: cnt = 0, go to DONE.
- State DONE:
  - line_resp_o = 1 for exactly one cycle, then unconditionally go to IDLE.
  - burst_read_o = burst_write_o = 0.
- line_rdata_o:
  - Driven from the line buffer; valid in the DONE cycle.
  - Held stable until the next READ accepts its first beat.
  - Not modified by writes: the write path uses a separate buffer, or the read buffer is untouched by write capture.
- Latency: line request to line_resp_o = 1 (capture) + N cycles until 4 beats + 1 (DONE). Minimum 6 cycles with back-to-back beats.
- L2 drops its request in the cycle after resp, so IDLE never re-triggers on a stale request. A request still high in IDLE is treated as a new transaction.
- burst_resp_i high in IDLE or DONE is ignored.
- line_wdata_i / line_address_i changes after capture have no effect.

Test Plan:
- Read, no gaps: reset, read addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles -> burst_address_o = 0x0000_1220; line_rdata_o = {44..,33..,22..,11..}; line_resp_o is a single pulse 6 cycles after the request.
- Read with gaps: beats separated by 0, 2, 1 idle cycles -> same assembled line; burst_read_o held continuously until the 4th beat; resp 1 cycle after the 4th beat.
- Write: line_wdata_i = 256'hDDDD...CCCC...BBBB...AAAA (beat0 = A), addr 0x8000_003F -> burst_address_o = 0x8000_0020; burst_wdata_o = A, B, C, D advancing only on burst_resp_i; single resp pulse.
- Simultaneous line_read_i and line_write_i high -> only burst_write_o asserts; after resp, read is serviced next if still requested.
- Reset mid-burst: assert rst low after 2 read beats -> all outputs 0 immediately; after release, a new read completes correctly with cnt starting at 0.
- Back-to-back: read then write issued the cycle after resp -> no stray resp; line_rdata_o from the read unchanged through the write.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the L2 single-line memory handshake to a 4-beat burst memory bus.
//   A 256-bit line read or write becomes BEATS consecutive BEAT_W transfers.
//   Only one transaction is in flight at a time.
//
// Handshake: the L2 holds line_read_i / line_write_i high until line_resp_o
//   pulses for one cycle. Downstream, burst_read_o / burst_write_o stay high
//   for the whole burst, and each cycle with burst_resp_i high moves exactly
//   one beat. Gaps between beats are legal.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   line_address_i     line address from L2 (low offset bits ignored)
//   line_wdata_i       line to write
//   line_rdata_o       assembled read line, valid in the resp cycle
//   line_read_i        read request
//   line_write_i       write request (wins over a simultaneous read)
//   line_resp_o        one-cycle completion pulse
//   burst_address_o    line-aligned burst address
//   burst_rdata_i      read beat from memory
//   burst_wdata_o      write beat to memory
//   burst_read_o       burst read request
//   burst_write_o      burst write request
//   burst_resp_i       beat strobe
//   dbg_state          current FSM state, for checkers
module cacheline_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32,
  localparam int LINE_W = BEAT_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_address_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  input  logic              line_read_i,
  input  logic              line_write_i,
  output logic              line_resp_o,
  output logic [ADDR_W-1:0] burst_address_o,
  input  logic [BEAT_W-1:0] burst_rdata_i,
  output logic [BEAT_W-1:0] burst_wdata_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  input  logic              burst_resp_i,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic [LINE_W-1:0] wbuf;
  logic [ADDR_W-1:0] aligned_addr;
  logic              unused_offset_bits;

  assign next_cnt           = cnt + 1'b1;
  assign aligned_addr       = {line_address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_offset_bits = ^line_address_i[OFF_W-1:0];
  assign dbg_state          = state;

  // line_rdata_o doubles as the read assembly buffer; write capture goes to
  // wbuf so a completed read line stays visible until the next read beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      wbuf            <= '0;
      line_rdata_o    <= '0;
      line_resp_o     <= 1'b0;
      burst_address_o <= '0;
      burst_wdata_o   <= '0;
      burst_read_o    <= 1'b0;
      burst_write_o   <= 1'b0;
    end else begin
      line_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (line_write_i) begin
            wbuf            <= line_wdata_i;
            burst_address_o <= aligned_addr;
            // First beat is presented straight from the request so it is
            // already stable in the first WRITE cycle.
            burst_wdata_o   <= line_wdata_i[BEAT_W-1:0];
            burst_write_o   <= 1'b1;
            state           <= WRITE;
          end else if (line_read_i) begin
            burst_address_o <= aligned_addr;
            burst_read_o    <= 1'b1;
            state           <= READ;
          end
        end

        READ: begin
          if (burst_resp_i) begin
            line_rdata_o[cnt*BEAT_W +: BEAT_W] <= burst_rdata_i;
            if (cnt == LAST_BEAT) begin
              cnt          <= '0;
              burst_read_o <= 1'b0;
              line_resp_o  <= 1'b1;
              state        <= DONE;
            end else begin
              cnt <= next_cnt;
            end
          end
        end

        WRITE: begin
          if (burst_resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt           <= '0;
              burst_write_o <= 1'b0;
              burst_wdata_o <= '0;
              line_resp_o   <= 1'b1;
              state         <= DONE;
            end else begin
              cnt           <= next_cnt;
              burst_wdata_o <= wbuf[next_cnt*BEAT_W +: BEAT_W];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
